// File: rtl/ddr_data_phase_ctrl.sv
// ----------------------------------------------------------------------------
// ddr_data_phase_ctrl
//
// Purpose:
//   Sequences the HDR-DDR target data phase that follows a decoded command
//   word. Each 20-bit word is walked as preamble (idx 0-1), data (idx 2-17)
//   and parity (idx 18-19). When the frame counter reports last_frame, the
//   CRC preamble and CRC word follow. Read transfers have the target driving
//   SDA. Write transfers have the host driving, and the host may end the
//   transfer early with a 2'b01 preamble.
//
// Handshake:
//   i_dpc_start is a 1-clk pulse that is only honoured in IDLE. All bit-level
//   advancement is qualified by i_dpc_bit_tick. i_dpc_abort overrides
//   everything except reset. There is no back-pressure.
//
// Ports:
//   i_dpc_clk          clock
//   i_dpc_rst_n        synchronous active-low reset
//   i_dpc_start        begin data phase (IDLE only)
//   i_dpc_rnw          1=read (target TX), 0=write; latched on start
//   i_dpc_bit_tick     one strobe per DDR bit slot
//   i_dpc_rx_bit       sampled SDA bit, used for write preamble decode
//   i_dpc_parity_err   parity result, meaningful on the idx-19 tick (write)
//   i_dpc_last_frame   frame counter word budget exhausted
//   i_dpc_abort        HDR exit/restart detected
//   o_dpc_fcnt_en      frame counter enable (low reloads the counter)
//   o_dpc_bit_count    bit index within the current word
//   o_dpc_toggle       frame counter decrement qualifier (once per data word)
//   o_dpc_tx_en        target drives SDA
//   o_dpc_tx_pre       preamble value the target drives on reads
//   o_dpc_crc_en       CRC engine accumulate enable
//   o_dpc_done         1-clk pulse on clean completion
//   o_dpc_error        sticky error, cleared by abort or reset
//   o_dpc_state        debug view of the FSM state (encoding below)
// ----------------------------------------------------------------------------
module ddr_data_phase_ctrl #(
    parameter int CRC_BITS = 9
) (
    input  logic       i_dpc_clk,
    input  logic       i_dpc_rst_n,
    input  logic       i_dpc_start,
    input  logic       i_dpc_rnw,
    input  logic       i_dpc_bit_tick,
    input  logic       i_dpc_rx_bit,
    input  logic       i_dpc_parity_err,
    input  logic       i_dpc_last_frame,
    input  logic       i_dpc_abort,
    output logic       o_dpc_fcnt_en,
    output logic [5:0] o_dpc_bit_count,
    output logic       o_dpc_toggle,
    output logic       o_dpc_tx_en,
    output logic [1:0] o_dpc_tx_pre,
    output logic       o_dpc_crc_en,
    output logic       o_dpc_done,
    output logic       o_dpc_error,
    output logic [2:0] o_dpc_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_CRC_PRE  = 3'd4,
        S_CRC_WORD = 3'd5,
        S_DONE     = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    // Every entry into CRC_WORD arrives with bit_count == 2. Both paths are
    // CRC_PRE idx 1 and the write early-end preamble idx 1. The last CRC
    // tick is therefore at idx CRC_BITS+1.
    localparam logic [5:0] CRC_LAST_IDX = 6'(CRC_BITS + 1);

    state_t     r_state;
    logic [5:0] r_bit_count;
    logic       r_rnw;
    logic       r_pre_b0;
    logic       r_fcnt_en;
    logic       r_tx_en;
    logic [1:0] r_tx_pre;
    logic       r_crc_en;
    logic       r_done;
    logic       r_error;

    state_t     w_state_nxt;
    logic [5:0] w_bit_count_nxt;
    logic [5:0] w_bit_count_inc;
    logic       w_rnw_nxt;
    logic       w_pre_b0_nxt;
    logic       w_active_nxt;

    assign w_bit_count_inc = r_bit_count + 6'd1;

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_count_nxt = r_bit_count;
        w_rnw_nxt       = r_rnw;
        w_pre_b0_nxt    = r_pre_b0;

        if (i_dpc_abort) begin
            w_state_nxt     = S_IDLE;
            w_bit_count_nxt = 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_bit_count_nxt = 6'd0;
                    if (i_dpc_start) begin
                        w_state_nxt = S_PREAMBLE;
                        w_rnw_nxt   = i_dpc_rnw;
                    end
                end
                S_PREAMBLE: begin
                    if (i_dpc_bit_tick) begin
                        w_bit_count_nxt = w_bit_count_inc;
                        if (r_bit_count == 6'd0) begin
                            w_pre_b0_nxt = i_dpc_rx_bit;
                        end else if (r_rnw) begin
                            w_state_nxt = S_DATA;
                        end else begin
                            // Host-driven preamble: 10 = another data word,
                            // 01 = host ends the transfer early.
                            case ({r_pre_b0, i_dpc_rx_bit})
                                2'b10:   w_state_nxt = S_DATA;
                                2'b01:   w_state_nxt = S_CRC_WORD;
                                default: w_state_nxt = S_ERROR;
                            endcase
                        end
                    end
                end
                S_DATA: begin
                    if (i_dpc_bit_tick) begin
                        w_bit_count_nxt = w_bit_count_inc;
                        if (r_bit_count == 6'd17) begin
                            w_state_nxt = S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (i_dpc_bit_tick) begin
                        w_bit_count_nxt = w_bit_count_inc;
                        if (r_bit_count == 6'd19) begin
                            if (!r_rnw && i_dpc_parity_err) begin
                                w_state_nxt = S_ERROR;
                            end else if (i_dpc_last_frame) begin
                                w_state_nxt     = S_CRC_PRE;
                                w_bit_count_nxt = 6'd0;
                            end else begin
                                w_state_nxt     = S_PREAMBLE;
                                w_bit_count_nxt = 6'd0;
                            end
                        end
                    end
                end
                S_CRC_PRE: begin
                    if (i_dpc_bit_tick) begin
                        w_bit_count_nxt = w_bit_count_inc;
                        if (r_bit_count == 6'd1) begin
                            w_state_nxt = S_CRC_WORD;
                        end
                    end
                end
                S_CRC_WORD: begin
                    if (i_dpc_bit_tick) begin
                        w_bit_count_nxt = w_bit_count_inc;
                        if (r_bit_count == CRC_LAST_IDX) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt     = S_IDLE;
                    w_bit_count_nxt = 6'd0;
                end
                S_ERROR: begin
                    w_state_nxt = S_ERROR;
                end
                default: begin
                    w_state_nxt     = S_IDLE;
                    w_bit_count_nxt = 6'd0;
                end
            endcase
        end
    end

    // The frame counter and the SDA drive are live only while a word or the
    // CRC is being walked.
    assign w_active_nxt = (w_state_nxt == S_PREAMBLE) || (w_state_nxt == S_DATA) ||
                          (w_state_nxt == S_PARITY)   || (w_state_nxt == S_CRC_PRE) ||
                          (w_state_nxt == S_CRC_WORD);

    // State register. Outputs are decoded from the next state, so each
    // registered output always agrees with r_state.
    always_ff @(posedge i_dpc_clk) begin
        if (!i_dpc_rst_n) begin
            r_state     <= S_IDLE;
            r_bit_count <= 6'd0;
            r_rnw       <= 1'b0;
            r_pre_b0    <= 1'b0;
            r_fcnt_en   <= 1'b0;
            r_tx_en     <= 1'b0;
            r_tx_pre    <= 2'b00;
            r_crc_en    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_count <= w_bit_count_nxt;
            r_rnw       <= w_rnw_nxt;
            r_pre_b0    <= w_pre_b0_nxt;
            r_fcnt_en   <= w_active_nxt;
            r_tx_en     <= w_active_nxt & w_rnw_nxt;
            if (w_rnw_nxt && (w_state_nxt == S_PREAMBLE)) begin
                r_tx_pre <= 2'b10;
            end else if (w_rnw_nxt && (w_state_nxt == S_CRC_PRE)) begin
                r_tx_pre <= 2'b01;
            end else begin
                r_tx_pre <= 2'b00;
            end
            r_crc_en    <= (w_state_nxt == S_DATA);
            r_done      <= (w_state_nxt == S_DONE);
            r_error     <= (w_state_nxt == S_ERROR);
        end
    end

    // The toggle is qualified by the tick itself, so it stays combinational.
    // It fires once per data word, on the tick at idx 16.
    assign o_dpc_toggle    = i_dpc_bit_tick && (r_state == S_DATA) && (r_bit_count == 6'd16);

    assign o_dpc_fcnt_en   = r_fcnt_en;
    assign o_dpc_bit_count = r_bit_count;
    assign o_dpc_tx_en     = r_tx_en;
    assign o_dpc_tx_pre    = r_tx_pre;
    assign o_dpc_crc_en    = r_crc_en;
    assign o_dpc_done      = r_done;
    assign o_dpc_error     = r_error;
    assign o_dpc_state     = r_state;

endmodule

// File: tb/tb_ddr_data_phase_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ddr_data_phase_ctrl
//
// Purpose:
//   Self-checking bench for ddr_data_phase_ctrl. It combines directed
//   scenarios with a randomized soak. The reference is a segment/position
//   model: segment idle/word/crc/done/error plus a bit position. Outputs are
//   derived arithmetically from that model and compared every cycle. A small
//   frame-counter stand-in supplies last_frame. A queue records the expected
//   data-word count for each transfer that completes cleanly.
// ----------------------------------------------------------------------------
module tb_ddr_data_phase_ctrl;

    localparam int CRC_BITS = 9;

    // ---------------- clock / reset ----------------
    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic       rst_n, start, rnw, bit_tick, rx_bit, parity_err, last_frame, abort;
    logic       fcnt_en, toggle, tx_en, crc_en, done, error;
    logic [5:0] bit_count;
    logic [1:0] tx_pre;
    logic [2:0] dbg_state;

    ddr_data_phase_ctrl #(.CRC_BITS(CRC_BITS)) dut (
        .i_dpc_clk        (clk),
        .i_dpc_rst_n      (rst_n),
        .i_dpc_start      (start),
        .i_dpc_rnw        (rnw),
        .i_dpc_bit_tick   (bit_tick),
        .i_dpc_rx_bit     (rx_bit),
        .i_dpc_parity_err (parity_err),
        .i_dpc_last_frame (last_frame),
        .i_dpc_abort      (abort),
        .o_dpc_fcnt_en    (fcnt_en),
        .o_dpc_bit_count  (bit_count),
        .o_dpc_toggle     (toggle),
        .o_dpc_tx_en      (tx_en),
        .o_dpc_tx_pre     (tx_pre),
        .o_dpc_crc_en     (crc_en),
        .o_dpc_done       (done),
        .o_dpc_error      (error),
        .o_dpc_state      (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    // staged one-shot / level controls applied at the next negedge
    bit s_rst_n = 1'b0, s_start = 1'b0, s_rnw = 1'b0, s_abort = 1'b0;
    int k_budget = 0;
    bit k_rand = 1'b0;
    int k_perr_word = -1;
    logic [1:0] k_pre_q[$];
    logic [1:0] cur_pre = 2'b10;

    // frame counter stand-in
    int fc_cnt = 0;
    bit fc_last = 1'b1;
    bit smp_fcnt = 1'b0, smp_tog = 1'b0;

    // reference model: seg 0 idle, 1 word, 2 crc, 3 done, 4 error
    int m_seg = 0, m_pos = 0, m_tog = 0, m_words = 0;
    bit m_rnw = 1'b0, m_b0 = 1'b0;

    // tallies for the directed scenarios
    int t_ticks, t_tog, t_done, t_pre10, t_pre01;
    int dut_tog = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic clear_tally();
        t_ticks = 0; t_tog = 0; t_done = 0; t_pre10 = 0; t_pre01 = 0;
    endtask

    // ---------------- expected outputs from the model ----------------
    function automatic logic [7:0] e_state();
        case (m_seg)
            0: return 8'd0;
            1: return (m_pos < 2) ? 8'd1 : (m_pos < 18) ? 8'd2 : 8'd3;
            2: return (m_pos < 2) ? 8'd4 : 8'd5;
            3: return 8'd6;
            default: return 8'd7;
        endcase
    endfunction

    function automatic logic e_active();
        return (m_seg == 1) || (m_seg == 2);
    endfunction

    function automatic logic [1:0] e_pre();
        if (m_rnw && m_seg == 1 && m_pos < 2) return 2'b10;
        if (m_rnw && m_seg == 2 && m_pos < 2) return 2'b01;
        return 2'b00;
    endfunction

    // ---------------- model update at the active edge ----------------
    task automatic model_update();
        if (!rst_n) begin
            m_seg = 0; m_pos = 0; m_rnw = 1'b0; m_b0 = 1'b0;
        end else if (abort) begin
            m_seg = 0; m_pos = 0;
        end else begin
            case (m_seg)
                0: if (start) begin
                    m_seg = 1; m_pos = 0; m_rnw = rnw; m_tog = 0; m_words = 0;
                end
                3: begin m_seg = 0; m_pos = 0; end
                1: if (bit_tick) begin
                    if (m_pos == 16) m_tog++;
                    if (m_pos == 0) begin
                        m_b0 = rx_bit; m_pos = 1;
                    end else if (m_pos == 1) begin
                        m_pos = 2;
                        if (!m_rnw) begin
                            if (k_pre_q.size() > 0) void'(k_pre_q.pop_front());
                            if ({m_b0, rx_bit} == 2'b01) m_seg = 2;
                            else if ({m_b0, rx_bit} != 2'b10) m_seg = 4;
                        end
                    end else if (m_pos == 19) begin
                        if (!m_rnw && parity_err) begin
                            m_seg = 4; m_pos = 20;
                        end else begin
                            m_words++;
                            m_pos = 0;
                            if (last_frame) m_seg = 2;
                        end
                    end else begin
                        m_pos++;
                    end
                end
                2: if (bit_tick) begin
                    if (m_pos == CRC_BITS + 1) begin
                        m_seg = 3;
                        exp_q.push_back(8'(m_tog));
                    end
                    m_pos++;
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- one clock: drive, compare, advance ----------------
    task automatic step();
        @(negedge clk);
        rst_n = s_rst_n; start = s_start; rnw = s_rnw; abort = s_abort;
        s_start = 1'b0; s_abort = 1'b0;
        bit_tick = k_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
        last_frame = fc_last;
        if (m_seg == 1 && m_pos == 0) begin
            if (k_pre_q.size() > 0) cur_pre = k_pre_q[0];
            else if (k_rand) begin
                case ($urandom_range(19, 0))
                    0: cur_pre = 2'b01;
                    1: cur_pre = 2'(($urandom_range(1, 0) != 0) ? 2'b11 : 2'b00);
                    default: cur_pre = 2'b10;
                endcase
            end else cur_pre = 2'b10;
        end
        if (m_seg == 1 && m_pos == 0)      rx_bit = cur_pre[1];
        else if (m_seg == 1 && m_pos == 1) rx_bit = cur_pre[0];
        else                               rx_bit = 1'($urandom_range(1, 0));
        if (m_seg == 1 && m_pos == 19)
            parity_err = k_rand ? ($urandom_range(19, 0) == 0) : (m_words == k_perr_word);
        else
            parity_err = 1'($urandom_range(1, 0));
        #1;
        chk("state",     {5'd0, dbg_state}, e_state());
        chk("fcnt_en",   {7'd0, fcnt_en},   {7'd0, e_active()});
        chk("bit_count", {2'd0, bit_count}, 8'(m_pos));
        chk("toggle",    {7'd0, toggle},    {7'd0, bit_tick && m_seg == 1 && m_pos == 16});
        chk("tx_en",     {7'd0, tx_en},     {7'd0, m_rnw && e_active()});
        chk("tx_pre",    {6'd0, tx_pre},    {6'd0, e_pre()});
        chk("crc_en",    {7'd0, crc_en},    {7'd0, m_seg == 1 && m_pos >= 2 && m_pos <= 17});
        chk("done",      {7'd0, done},      {7'd0, m_seg == 3});
        chk("error",     {7'd0, error},     {7'd0, m_seg == 4});
        // tallies and the per-transfer scoreboard, from DUT observations
        if (bit_tick && fcnt_en === 1'b1) t_ticks++;
        if (bit_tick && tx_pre === 2'b10) t_pre10++;
        if (bit_tick && tx_pre === 2'b01) t_pre01++;
        if (toggle === 1'b1) t_tog++;
        if (dbg_state === 3'd0) dut_tog = 0;
        if (toggle === 1'b1) dut_tog++;
        if (done === 1'b1) begin
            t_done++;
            if (exp_q.size() == 0) chk("sb_unexpected_done", 8'd1, 8'd0);
            else chk("sb_words", 8'(dut_tog), exp_q.pop_front());
            dut_tog = 0;
        end
        smp_fcnt = fcnt_en; smp_tog = toggle;
        @(posedge clk);
        #1;
        model_update();
        if (!smp_fcnt) fc_cnt = k_budget;
        else if (smp_tog && fc_cnt > 0) fc_cnt--;
        fc_last = (fc_cnt == 0);
    endtask

    function automatic bit cond_met(input int mode);
        case (mode)
            0: return m_seg == 0;
            1: return m_seg == 4;
            default: return m_seg == 1 && m_pos == 10;
        endcase
    endfunction

    task automatic run_until(input int mode, input int max_cyc, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!cond_met(mode) && n < max_cyc);
        if (!cond_met(mode)) begin
            n_checks++; n_fail++;
            $display("FAIL timeout %s: no progress after %0d cycles", name, n);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b1; rnw = 1'b0; bit_tick = 1'b0; rx_bit = 1'b0;
        parity_err = 1'b0; last_frame = 1'b0; abort = 1'b0;
        clear_tally();

        // Reset held two clocks with start asserted.
        s_rst_n = 1'b0; s_start = 1'b1; step();
        s_start = 1'b1; step();
        chk("rst_state", {5'd0, dbg_state}, 8'd0);
        chk("rst_done",  {7'd0, done}, 8'd0);
        chk("rst_fcnt",  {7'd0, fcnt_en}, 8'd0);
        s_rst_n = 1'b1;

        // Read, three words.
        k_budget = 3; step();
        clear_tally(); s_start = 1'b1; s_rnw = 1'b1;
        run_until(0, 300, "read3");
        chk("read3_ticks", 8'(t_ticks), 8'd71);
        chk("read3_tog",   8'(t_tog),   8'd3);
        chk("read3_done",  8'(t_done),  8'd1);
        chk("read3_pre10", 8'(t_pre10), 8'd6);
        chk("read3_pre01", 8'(t_pre01), 8'd2);

        // Zero-length read still runs one word.
        k_budget = 0; step();
        clear_tally(); s_start = 1'b1; s_rnw = 1'b1;
        run_until(0, 200, "read0");
        chk("read0_ticks", 8'(t_ticks), 8'd31);
        chk("read0_tog",   8'(t_tog),   8'd1);
        chk("read0_done",  8'(t_done),  8'd1);

        // Write with a host early end.
        k_budget = 3; step();
        k_pre_q = '{2'b10, 2'b01};
        clear_tally(); s_start = 1'b1; s_rnw = 1'b0;
        run_until(0, 200, "write_early");
        chk("wearly_ticks", 8'(t_ticks), 8'd31);
        chk("wearly_tog",   8'(t_tog),   8'd1);
        chk("wearly_done",  8'(t_done),  8'd1);
        chk("wearly_pre10", 8'(t_pre10), 8'd0);

        // Write with a bad preamble, then recovery by abort.
        k_pre_q = '{2'b11};
        clear_tally(); s_start = 1'b1; s_rnw = 1'b0;
        run_until(1, 50, "bad_pre");
        step();
        chk("badpre_error", {7'd0, error}, 8'd1);
        chk("badpre_fcnt",  {7'd0, fcnt_en}, 8'd0);
        s_abort = 1'b1; step();
        chk("badpre_err_clr", {7'd0, error}, 8'd0);
        chk("badpre_idle",    {5'd0, dbg_state}, 8'd0);

        // Write with a parity error in word 2.
        k_pre_q.delete(); k_budget = 3; k_perr_word = 1; step();
        clear_tally(); s_start = 1'b1; s_rnw = 1'b0;
        run_until(1, 200, "parity_err");
        chk("perr_error", {7'd0, error}, 8'd1);
        chk("perr_done",  8'(t_done), 8'd0);
        s_abort = 1'b1; step();
        k_perr_word = -1;

        // Abort at data idx 10 with start in the same cycle, then restart.
        step();
        clear_tally(); s_start = 1'b1; s_rnw = 1'b1;
        run_until(2, 50, "reach_idx10");
        s_abort = 1'b1; s_start = 1'b1; step();
        chk("abort_idle", {5'd0, dbg_state}, 8'd0);
        chk("abort_bc",   {2'd0, bit_count}, 8'd0);
        chk("abort_done", 8'(t_done), 8'd0);
        clear_tally(); s_start = 1'b1; s_rnw = 1'b1;
        run_until(0, 300, "restart");
        chk("restart_done", 8'(t_done), 8'd1);

        // Randomized soak.
        k_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            s_rst_n = ($urandom_range(599, 0) != 0);
            s_abort = ($urandom_range(249, 0) == 0);
            s_rnw   = 1'($urandom_range(1, 0));
            if (m_seg == 0) k_budget = $urandom_range(3, 0);
            s_start = (m_seg == 0) ? ($urandom_range(3, 0) == 0) : ($urandom_range(15, 0) == 0);
            step();
        end
        k_rand = 1'b0; s_rst_n = 1'b1;
        s_abort = 1'b1; step();
        step();
        chk("sb_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
